// File: rtl/fasttwosum_sched.sv
// Round-robin scheduler feeding one shared fasttwosum datapath from NUM_REQ requesters.
// Issue is credit-limited so every result always has a slot in the result FIFO.
module fasttwosum_sched #(
    parameter int EXP_WIDTH_I  = 5,
    parameter int MANT_WIDTH_I = 2,
    parameter int NUM_REQ      = 4,
    parameter int PIPE_LAT     = 4,
    parameter int FIFO_DEPTH   = 8,
    localparam int BW          = 1 + EXP_WIDTH_I + MANT_WIDTH_I,
    localparam int IDW         = $clog2(NUM_REQ)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      enable_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ*4*BW-1:0]   req_data_i,
    output logic                      dp_valid_o,
    output logic [BW-1:0]             dp_e0_o,
    output logic [BW-1:0]             dp_e1_o,
    output logic [BW-1:0]             dp_e2_o,
    output logic [BW-1:0]             dp_e3_o,
    input  logic [BW-1:0]             dp_sum_a_i,
    input  logic [BW-1:0]             dp_sum_b_i,
    input  logic [BW-1:0]             dp_error_a_i,
    input  logic [BW-1:0]             dp_error_b_i,
    output logic                      res_valid_o,
    input  logic                      res_ready_i,
    output logic [IDW-1:0]            res_id_o,
    output logic [4*BW-1:0]           res_data_o,
    output logic                      busy_o
);
    localparam int PW = 4 * BW;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [IDW-1:0]     r_rr_ptr;
    logic [CW-1:0]      r_credits;
    logic               r_dp_valid;
    logic [IDW-1:0]     r_dp_id;
    logic [PW-1:0]      r_dp_pkt;
    logic [PIPE_LAT-1:0] r_tag_valid;
    logic [IDW-1:0]     r_tag_id [PIPE_LAT];
    logic [IDW+PW-1:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_mem_cnt;
    logic               r_res_valid;
    logic [IDW-1:0]     r_res_id;
    logic [PW-1:0]      r_res_data;

    logic               w_can_issue;
    logic [IDW-1:0]     w_grant_id;
    logic [IDW-1:0]     w_cand;
    logic               w_found;
    logic [PW-1:0]      w_sel_pkt;
    logic               w_pop;
    logic               w_push;
    logic [IDW+PW-1:0]  w_push_entry;
    logic               w_head_load;
    logic               w_mem_empty;
    logic               w_bypass;
    logic               w_mem_wr;
    logic               w_mem_rd;

    // Rotating priority scan starting just after the last granted requester.
    always_comb begin
        w_found    = 1'b0;
        w_grant_id = '0;
        w_cand     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = IDW'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_found && req_valid_i[w_cand]) begin
                w_found    = 1'b1;
                w_grant_id = w_cand;
            end
        end
    end

    assign w_can_issue = !rst_i && enable_i && (r_credits < CW'(FIFO_DEPTH)) && w_found;
    assign req_ready_o = w_can_issue ? (NUM_REQ'(1) << w_grant_id) : '0;
    assign w_sel_pkt   = req_data_i[w_grant_id*PW +: PW];

    assign w_pop        = r_res_valid & res_ready_i;
    assign w_push       = r_tag_valid[PIPE_LAT-1];
    assign w_push_entry = {r_tag_id[PIPE_LAT-1], dp_error_b_i, dp_error_a_i, dp_sum_b_i, dp_sum_a_i};
    assign w_head_load  = !r_res_valid || res_ready_i;
    assign w_mem_empty  = (r_mem_cnt == '0);
    // An empty FIFO lets the incoming result go straight into the head register.
    assign w_bypass     = w_head_load && w_mem_empty && w_push;
    assign w_mem_wr     = w_push && !w_bypass;
    assign w_mem_rd     = w_head_load && !w_mem_empty;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr_ptr   <= IDW'(NUM_REQ - 1);
            r_dp_valid <= 1'b0;
            r_dp_id    <= '0;
            r_dp_pkt   <= '0;
            r_credits  <= '0;
        end else begin
            r_dp_valid <= w_can_issue;
            if (w_can_issue) begin
                r_dp_id  <= w_grant_id;
                r_dp_pkt <= w_sel_pkt;
                r_rr_ptr <= w_grant_id;
            end
            if (w_can_issue && !w_pop) begin
                r_credits <= r_credits + 1'b1;
            end else if (!w_can_issue && w_pop) begin
                r_credits <= r_credits - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tag_valid <= '0;
            for (int s = 0; s < PIPE_LAT; s++) begin
                r_tag_id[s] <= '0;
            end
        end else begin
            r_tag_valid[0] <= r_dp_valid;
            r_tag_id[0]    <= r_dp_id;
            for (int s = 1; s < PIPE_LAT; s++) begin
                r_tag_valid[s] <= r_tag_valid[s-1];
                r_tag_id[s]    <= r_tag_id[s-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_mem_wr) begin
            r_mem[r_wr_ptr] <= w_push_entry;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_mem_cnt   <= '0;
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_data  <= '0;
        end else begin
            if (w_mem_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_mem_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_mem_wr && !w_mem_rd) begin
                r_mem_cnt <= r_mem_cnt + 1'b1;
            end else if (!w_mem_wr && w_mem_rd) begin
                r_mem_cnt <= r_mem_cnt - 1'b1;
            end
            if (w_head_load) begin
                if (!w_mem_empty) begin
                    r_res_valid            <= 1'b1;
                    {r_res_id, r_res_data} <= r_mem[r_rd_ptr];
                end else if (w_push) begin
                    r_res_valid            <= 1'b1;
                    {r_res_id, r_res_data} <= w_push_entry;
                end else begin
                    r_res_valid <= 1'b0;
                end
            end
        end
    end

    assign dp_valid_o  = r_dp_valid;
    assign dp_e0_o     = r_dp_pkt[0*BW +: BW];
    assign dp_e1_o     = r_dp_pkt[1*BW +: BW];
    assign dp_e2_o     = r_dp_pkt[2*BW +: BW];
    assign dp_e3_o     = r_dp_pkt[3*BW +: BW];
    assign res_valid_o = r_res_valid;
    assign res_id_o    = r_res_id;
    assign res_data_o  = r_res_data;
    assign busy_o      = (r_credits != '0);
endmodule

// File: tb/tb_fasttwosum_sched.sv
// Bench for fasttwosum_sched: directed request patterns, a stand-in datapath pipeline,
// and a scoreboard queue filled at grant time and drained by a result monitor.
module tb_fasttwosum_sched;
    localparam int BW = 8;
    localparam int NUM_REQ = 4;
    localparam int PIPE_LAT = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int PW = 4 * BW;

    typedef struct packed {
        logic [1:0]    id;
        logic [PW-1:0] data;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst, en, res_ready;
    logic [NUM_REQ-1:0]      req_valid, req_ready;
    logic [NUM_REQ*PW-1:0]   req_data;
    logic                    dp_valid;
    logic [BW-1:0]           dp_e0, dp_e1, dp_e2, dp_e3;
    logic [BW-1:0]           dp_sum_a, dp_sum_b, dp_err_a, dp_err_b;
    logic                    res_valid;
    logic [1:0]              res_id;
    logic [PW-1:0]           res_data;
    logic                    busy;

    int   n_vec = 0;
    int   n_err = 0;
    int   grant_cnt = 0;
    int   pop_cnt = 0;
    int   cur_idx [NUM_REQ];
    bit   fixed_pkt = 1'b0;
    exp_t sbq [$];
    logic [PW-1:0] dp_pipe [PIPE_LAT];

    always #5 clk = ~clk;

    fasttwosum_sched #(
        .EXP_WIDTH_I(5), .MANT_WIDTH_I(2), .NUM_REQ(NUM_REQ),
        .PIPE_LAT(PIPE_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(en),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data),
        .dp_valid_o(dp_valid), .dp_e0_o(dp_e0), .dp_e1_o(dp_e1), .dp_e2_o(dp_e2), .dp_e3_o(dp_e3),
        .dp_sum_a_i(dp_sum_a), .dp_sum_b_i(dp_sum_b), .dp_error_a_i(dp_err_a), .dp_error_b_i(dp_err_b),
        .res_valid_o(res_valid), .res_ready_i(res_ready), .res_id_o(res_id), .res_data_o(res_data),
        .busy_o(busy)
    );

    // Packets {e3,e2,e1,e0}
    function automatic logic [PW-1:0] pkt_f(input int i);
        case (i)
            0: return 32'h40403C3C;
            1: return 32'h04030201;
            2: return 32'h20F02010;
            3: return 32'h808001FF;
            4: return 32'hF00FAA55;
            5: return 32'h78563412;
            6: return 32'h01007F7F;
            default: return 32'h5BA53CC3;
        endcase
    endfunction

    // Hand-computed {error_b,error_a,sum_b,sum_a} for the stand-in datapath
    function automatic logic [PW-1:0] res_f(input int i);
        case (i)
            0: return 32'h00008078;
            1: return 32'h07030703;
            2: return 32'hD0301030;
            3: return 32'h00FE0000;
            4: return 32'hFFFFFFFF;
            5: return 32'h2E26CE46;
            6: return 32'h010001FE;
            default: return 32'hFEFF00FF;
        endcase
    endfunction

    // Stand-in datapath: sums and xors of element pairs
    function automatic logic [PW-1:0] dp_f(input logic [PW-1:0] p);
        logic [BW-1:0] e0, e1, e2, e3, sa, sb;
        e0 = p[7:0]; e1 = p[15:8]; e2 = p[23:16]; e3 = p[31:24];
        sa = e0 + e1;
        sb = e2 + e3;
        return {e2 ^ e3, e0 ^ e1, sb, sa};
    endfunction

    always @(posedge clk) begin
        dp_pipe[0] <= dp_f({dp_e3, dp_e2, dp_e1, dp_e0});
        for (int i = 1; i < PIPE_LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
    end
    assign {dp_err_b, dp_err_a, dp_sum_b, dp_sum_a} = dp_pipe[PIPE_LAT-1];

    always_comb begin
        req_data = '0;
        for (int r = 0; r < NUM_REQ; r++)
            req_data[r*PW +: PW] = pkt_f(fixed_pkt ? 0 : cur_idx[r]);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || res_valid) && n < 200) begin
            tick();
            n++;
        end
        chk("drain_in_time", n < 200, 1);
    endtask

    // Grant model and scoreboard producer
    initial begin : issue_model
        int rr_m, cred_m, gid, c, prev_idx, idx;
        bit pop, prev_g;
        logic [NUM_REQ-1:0] exp_oh;
        rr_m = NUM_REQ - 1; cred_m = 0; prev_g = 0; prev_idx = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rr_m = NUM_REQ - 1; cred_m = 0; prev_g = 0;
                sbq.delete();
            end else begin
                chk("dp_valid", dp_valid, prev_g);
                if (prev_g) chk("dp_pkt", {dp_e3, dp_e2, dp_e1, dp_e0}, pkt_f(prev_idx));
                gid = -1;
                if (en && cred_m < FIFO_DEPTH)
                    for (int k = 1; k <= NUM_REQ; k++) begin
                        c = (rr_m + k) % NUM_REQ;
                        if (gid < 0 && req_valid[c]) gid = c;
                    end
                exp_oh = '0;
                if (gid >= 0) exp_oh[gid] = 1'b1;
                chk("req_ready", req_ready, exp_oh);
                chk("busy", busy, cred_m != 0);
                pop = res_valid & res_ready;
                prev_g = (gid >= 0);
                if (gid >= 0) begin
                    idx = fixed_pkt ? 0 : cur_idx[gid];
                    prev_idx = idx;
                    sbq.push_back({2'(gid), res_f(idx)});
                    rr_m = gid;
                    grant_cnt++;
                    cred_m++;
                end
                if (pop) cred_m--;
                @(posedge clk);
                #1;
                if (gid >= 0 && !fixed_pkt) cur_idx[gid] = (cur_idx[gid] + 3) % 8;
            end
        end
    end

    // Result monitor
    initial begin : result_monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && res_valid && res_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("res_id", res_id, e.id);
                    chk("res_data", res_data, e.data);
                    pop_cnt++;
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        int n, g0, p0;
        rst = 1; en = 0; req_valid = '0; res_ready = 0;
        for (int r = 0; r < NUM_REQ; r++) cur_idx[r] = r * 2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_dp_valid", dp_valid, 0);
        chk("rst_dp_e", {dp_e3, dp_e2, dp_e1, dp_e0}, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_busy", busy, 0);
        tick();
        rst = 0;

        // 1: all requesters, consumer always ready
        en = 1; res_ready = 1; req_valid = 4'hF;
        @(negedge clk);
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (res_valid) break;
        end
        chk("t1_latency", n, PIPE_LAT + 2);
        chk("t1_first_id", res_id, 0);
        repeat (12) tick();
        req_valid = '0;
        wait_idle();

        // 2: single persistent requester with a fixed packet
        fixed_pkt = 1; req_valid = 4'b0100;
        n = 0;
        @(negedge clk);
        while (!res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t2_id", res_id, 2);
        chk("t2_data", res_data, 32'h00008078);
        repeat (8) tick();
        req_valid = '0;
        wait_idle();
        fixed_pkt = 0;

        // 3/4: consumer stalled, credits exhausted, then one pop
        g0 = grant_cnt;
        res_ready = 0; req_valid = 4'hF;
        repeat (12) tick();
        @(negedge clk);
        chk("t3_grants", grant_cnt - g0, FIFO_DEPTH);
        chk("t3_ready_off", req_ready, 0);
        chk("t3_busy", busy, 1);
        chk("t3_res_valid", res_valid, 1);
        tick();
        res_ready = 1;
        @(negedge clk);
        chk("t4_no_grant_on_pop", req_ready, 0);
        tick();
        res_ready = 0;
        @(negedge clk);
        chk("t4_grant_after_pop", req_ready != 0, 1);
        tick();
        @(negedge clk);
        chk("t4_ready_off_again", req_ready, 0);
        chk("t4_grants", grant_cnt - g0, FIFO_DEPTH + 1);
        tick();
        res_ready = 1; req_valid = '0;
        wait_idle();

        // 5: enable dropped after three grants
        g0 = grant_cnt; p0 = pop_cnt;
        req_valid = 4'hF;
        repeat (3) tick();
        en = 0;
        repeat (3) tick();
        chk("t5_grants", grant_cnt - g0, 3);
        wait_idle();
        chk("t5_pops", pop_cnt - p0, 3);
        chk("t5_busy", busy, 0);

        // 6: reset with packets in flight
        en = 1;
        repeat (5) tick();
        rst = 1; req_valid = '0;
        #1;
        chk("t6_req_ready", req_ready, 0);
        chk("t6_dp_valid", dp_valid, 0);
        chk("t6_dp_e", {dp_e3, dp_e2, dp_e1, dp_e0}, 0);
        chk("t6_res_valid", res_valid, 0);
        chk("t6_res_id", res_id, 0);
        chk("t6_res_data", res_data, 0);
        chk("t6_busy", busy, 0);
        repeat (2) tick();
        rst = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t6_no_stale_result", res_valid, 0);
        end
        tick();
        req_valid = 4'hF;
        @(negedge clk);
        chk("t6_first_grant", req_ready, 4'b0001);
        repeat (6) tick();
        req_valid = '0;
        wait_idle();
        repeat (2) tick();
        chk("scoreboard_empty", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
